// File: rtl/vga_sync_if.sv
// Raster timing bundle from the VGA sync generator to the image generator and DAC.
// The sync controller drives the master side; the image generator and DAC read the slave side.
interface vga_sync_if;
    logic        h_sync;
    logic        v_sync;
    logic        disp_ena;
    logic [31:0] column;
    logic [31:0] row;
    logic        n_blank;
    logic        n_sync;
    logic        frame_start;

    modport master (
        output h_sync, v_sync, disp_ena, column, row, n_blank, n_sync, frame_start
    );

    modport slave (
        input  h_sync, v_sync, disp_ena, column, row, n_blank, n_sync, frame_start
    );
endinterface

// File: rtl/vga_sync_controller.sv
// Free-running VGA raster generator (640x480@60 by default): horizontal and vertical
// counters with registered sync, display-enable, pixel coordinates and frame-start pulse.
module vga_sync_controller #(
    parameter int unsigned H_PIXELS = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_PULSE  = 96,
    parameter int unsigned H_BP     = 48,
    parameter bit          H_POL    = 1'b0,
    parameter int unsigned V_PIXELS = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_PULSE  = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          V_POL    = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    vga_sync_if.master    vga
);

    localparam int unsigned H_PER = H_PIXELS + H_FP + H_PULSE + H_BP;
    localparam int unsigned V_PER = V_PIXELS + V_FP + V_PULSE + V_BP;

    localparam logic [11:0] H_ACT        = 12'(H_PIXELS);
    localparam logic [11:0] H_SYNC_FIRST = 12'(H_PIXELS + H_FP);
    localparam logic [11:0] H_SYNC_LAST  = 12'(H_PIXELS + H_FP + H_PULSE - 1);
    localparam logic [11:0] H_LAST       = 12'(H_PER - 1);
    localparam logic [11:0] V_ACT        = 12'(V_PIXELS);
    localparam logic [11:0] V_SYNC_FIRST = 12'(V_PIXELS + V_FP);
    localparam logic [11:0] V_SYNC_LAST  = 12'(V_PIXELS + V_FP + V_PULSE - 1);
    localparam logic [11:0] V_LAST       = 12'(V_PER - 1);

    logic [11:0] h_cnt_reg, h_cnt_next;
    logic [11:0] v_cnt_reg, v_cnt_next;
    logic        h_sync_reg, h_sync_next;
    logic        v_sync_reg, v_sync_next;
    logic        disp_ena_reg, disp_ena_next;
    logic [11:0] column_reg, column_next;
    logic [11:0] row_reg, row_next;
    logic        frame_start_reg, frame_start_next;

    logic h_active, v_active, h_in_pulse, v_in_pulse;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            h_sync_reg      <= ~H_POL;
            v_sync_reg      <= ~V_POL;
            disp_ena_reg    <= 1'b0;
            column_reg      <= '0;
            row_reg         <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            h_cnt_reg       <= h_cnt_next;
            v_cnt_reg       <= v_cnt_next;
            h_sync_reg      <= h_sync_next;
            v_sync_reg      <= v_sync_next;
            disp_ena_reg    <= disp_ena_next;
            column_reg      <= column_next;
            row_reg         <= row_next;
            frame_start_reg <= frame_start_next;
        end
    end

    // Outputs are decoded from the current counter values, so they lag the counters by one edge.
    always_comb begin
        h_cnt_next = h_cnt_reg + 12'd1;
        v_cnt_next = v_cnt_reg;
        if (h_cnt_reg == H_LAST) begin
            h_cnt_next = '0;
            v_cnt_next = (v_cnt_reg == V_LAST) ? 12'd0 : v_cnt_reg + 12'd1;
        end

        h_active   = (h_cnt_reg < H_ACT);
        v_active   = (v_cnt_reg < V_ACT);
        h_in_pulse = (h_cnt_reg >= H_SYNC_FIRST) && (h_cnt_reg <= H_SYNC_LAST);
        v_in_pulse = (v_cnt_reg >= V_SYNC_FIRST) && (v_cnt_reg <= V_SYNC_LAST);

        h_sync_next      = h_in_pulse ? H_POL : ~H_POL;
        v_sync_next      = v_in_pulse ? V_POL : ~V_POL;
        disp_ena_next    = h_active && v_active;
        // Coordinates freeze at their last active value during blanking.
        column_next      = h_active ? h_cnt_reg : column_reg;
        row_next         = v_active ? v_cnt_reg : row_reg;
        frame_start_next = (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
    end

    assign vga.h_sync      = h_sync_reg;
    assign vga.v_sync      = v_sync_reg;
    assign vga.disp_ena    = disp_ena_reg;
    assign vga.column      = {20'd0, column_reg};
    assign vga.row         = {20'd0, row_reg};
    assign vga.n_blank     = disp_ena_reg;
    assign vga.n_sync      = 1'b0;
    assign vga.frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_controller.sv
// Directed bench for vga_sync_controller: default 640x480 timing, inverted-polarity copy,
// and a tiny raster instance that exercises whole-frame wrap behaviour within a short run.
module tb_vga_sync_controller;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #20 clk = ~clk;

    vga_sync_if main_if ();
    vga_sync_if pol_if ();
    vga_sync_if tiny_if ();

    vga_sync_controller u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .vga     (main_if.master)
    );

    vga_sync_controller #(.H_POL(1'b1), .V_POL(1'b1)) u_pol (
        .clk     (clk),
        .reset_n (reset_n),
        .vga     (pol_if.master)
    );

    // Tiny raster: H 8+2+3+2 = 15 clocks, V 4+1+2+1 = 8 lines, frame = 120 clocks.
    vga_sync_controller #(
        .H_PIXELS(8), .H_FP(2), .H_PULSE(3), .H_BP(2), .H_POL(1'b1),
        .V_PIXELS(4), .V_FP(1), .V_PULSE(2), .V_BP(1), .V_POL(1'b1)
    ) u_tiny (
        .clk     (clk),
        .reset_n (reset_n),
        .vga     (tiny_if.master)
    );

    int check_count = 0;
    int error_count = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("check %s ok (%0d)", tag, got);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check_val({pfx, "_h_sync"},      32'(main_if.h_sync),      32'd1);
        check_val({pfx, "_v_sync"},      32'(main_if.v_sync),      32'd1);
        check_val({pfx, "_disp_ena"},    32'(main_if.disp_ena),    32'd0);
        check_val({pfx, "_n_blank"},     32'(main_if.n_blank),     32'd0);
        check_val({pfx, "_n_sync"},      32'(main_if.n_sync),      32'd0);
        check_val({pfx, "_column"},      main_if.column,           32'd0);
        check_val({pfx, "_row"},         main_if.row,              32'd0);
        check_val({pfx, "_frame_start"}, 32'(main_if.frame_start), 32'd0);
        check_val({pfx, "_pol_h_sync"},  32'(pol_if.h_sync),       32'd0);
        check_val({pfx, "_pol_v_sync"},  32'(pol_if.v_sync),       32'd0);
        check_val({pfx, "_tiny_v_sync"}, 32'(tiny_if.v_sync),      32'd0);
    endtask

    // Start-of-raster checks shared by the initial run and the run after a mid-frame reset.
    task automatic check_start(input string pfx, input int k);
        if (k == 1) begin
            check_val({pfx, "_e1_disp_ena"},    32'(main_if.disp_ena),    32'd1);
            check_val({pfx, "_e1_column"},      main_if.column,           32'd0);
            check_val({pfx, "_e1_row"},         main_if.row,              32'd0);
            check_val({pfx, "_e1_frame_start"}, 32'(main_if.frame_start), 32'd1);
            check_val({pfx, "_e1_n_blank"},     32'(main_if.n_blank),     32'd1);
        end
        if (k == 2) begin
            check_val({pfx, "_e2_frame_start"}, 32'(main_if.frame_start), 32'd0);
            check_val({pfx, "_e2_column"},      main_if.column,           32'd1);
        end
        if (k == 640) begin
            check_val({pfx, "_e640_column"},   main_if.column,        32'd639);
            check_val({pfx, "_e640_disp_ena"}, 32'(main_if.disp_ena), 32'd1);
        end
        if (k == 641) begin
            check_val({pfx, "_e641_disp_ena"}, 32'(main_if.disp_ena), 32'd0);
            check_val({pfx, "_e641_column"},   main_if.column,        32'd639);
        end
    endtask

    int h_low_line0, h_low_line1, de_two_lines, pol_high_line0;
    int nb_mismatch, nsync_ones, pol_mismatch, main_fs_count;
    int tiny_vs_high, tiny_hs_high, tiny_de_count, tiny_fs_count, tiny_fs_first, tiny_fs_second;

    initial begin
        h_low_line0 = 0; h_low_line1 = 0; de_two_lines = 0; pol_high_line0 = 0;
        nb_mismatch = 0; nsync_ones = 0; pol_mismatch = 0; main_fs_count = 0;
        tiny_vs_high = 0; tiny_hs_high = 0; tiny_de_count = 0;
        tiny_fs_count = 0; tiny_fs_first = 0; tiny_fs_second = 0;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");
        reset_n = 1'b1;

        // Edge k shows raster position k-1 (h = (k-1) % 800, v = (k-1) / 800).
        for (int k = 1; k <= 1801; k++) begin
            @(posedge clk);
            @(negedge clk);

            if (main_if.n_blank !== main_if.disp_ena) nb_mismatch++;
            if (main_if.n_sync !== 1'b0) nsync_ones++;
            if (pol_if.h_sync !== ~main_if.h_sync || pol_if.v_sync !== ~main_if.v_sync) pol_mismatch++;
            if (main_if.frame_start) main_fs_count++;
            if (k <= 800 && !main_if.h_sync) h_low_line0++;
            if (k > 800 && k <= 1600 && !main_if.h_sync) h_low_line1++;
            if (k <= 1600 && main_if.disp_ena) de_two_lines++;
            if (k <= 800 && pol_if.h_sync) pol_high_line0++;
            if (k <= 120) begin
                if (tiny_if.v_sync) tiny_vs_high++;
                if (tiny_if.h_sync) tiny_hs_high++;
                if (tiny_if.disp_ena) tiny_de_count++;
            end
            if (k <= 240 && tiny_if.frame_start) begin
                tiny_fs_count++;
                if (tiny_fs_first == 0) tiny_fs_first = k;
                else tiny_fs_second = k;
            end

            check_start("run1", k);
            if (k == 1) begin
                check_val("pol_e1_h_sync", 32'(pol_if.h_sync), 32'd0);
                check_val("pol_e1_v_sync", 32'(pol_if.v_sync), 32'd0);
            end
            if (k == 656) check_val("e656_h_sync", 32'(main_if.h_sync), 32'd1);
            if (k == 657) begin
                check_val("e657_h_sync", 32'(main_if.h_sync), 32'd0);
                check_val("pol_e657_h_sync", 32'(pol_if.h_sync), 32'd1);
            end
            if (k == 752) check_val("e752_h_sync", 32'(main_if.h_sync), 32'd0);
            if (k == 753) begin
                check_val("e753_h_sync", 32'(main_if.h_sync), 32'd1);
                check_val("pol_e753_h_sync", 32'(pol_if.h_sync), 32'd0);
            end
            if (k == 800) begin
                check_val("e800_column", main_if.column, 32'd639);
                check_val("e800_row",    main_if.row,    32'd0);
            end
            if (k == 801) begin
                check_val("e801_column",      main_if.column,           32'd0);
                check_val("e801_row",         main_if.row,              32'd1);
                check_val("e801_disp_ena",    32'(main_if.disp_ena),    32'd1);
                check_val("e801_frame_start", 32'(main_if.frame_start), 32'd0);
            end
            if (k == 1456) check_val("e1456_h_sync", 32'(main_if.h_sync), 32'd1);
            if (k == 1457) check_val("e1457_h_sync", 32'(main_if.h_sync), 32'd0);
            if (k == 1801) begin
                check_val("e1801_row",      main_if.row,           32'd2);
                check_val("e1801_column",   main_if.column,        32'd200);
                check_val("e1801_disp_ena", 32'(main_if.disp_ena), 32'd1);
            end

            // Tiny raster: line = 15 clocks, v_sync on lines 5..6, active 8x4.
            if (k == 8) begin
                check_val("tiny_e8_column",   tiny_if.column,        32'd7);
                check_val("tiny_e8_disp_ena", 32'(tiny_if.disp_ena), 32'd1);
            end
            if (k == 9) begin
                check_val("tiny_e9_column",   tiny_if.column,        32'd7);
                check_val("tiny_e9_disp_ena", 32'(tiny_if.disp_ena), 32'd0);
            end
            if (k == 61) begin
                check_val("tiny_e61_row",      tiny_if.row,           32'd3);
                check_val("tiny_e61_disp_ena", 32'(tiny_if.disp_ena), 32'd0);
            end
            if (k == 75)  check_val("tiny_e75_v_sync",  32'(tiny_if.v_sync), 32'd0);
            if (k == 76)  check_val("tiny_e76_v_sync",  32'(tiny_if.v_sync), 32'd1);
            if (k == 105) check_val("tiny_e105_v_sync", 32'(tiny_if.v_sync), 32'd1);
            if (k == 106) check_val("tiny_e106_v_sync", 32'(tiny_if.v_sync), 32'd0);
            if (k == 120) check_val("tiny_e120_row",    tiny_if.row,         32'd3);
            if (k == 121) begin
                check_val("tiny_e121_row",         tiny_if.row,              32'd0);
                check_val("tiny_e121_column",      tiny_if.column,           32'd0);
                check_val("tiny_e121_frame_start", 32'(tiny_if.frame_start), 32'd1);
                check_val("tiny_e121_disp_ena",    32'(tiny_if.disp_ena),    32'd1);
            end
        end

        check_val("h_sync_low_line0",    32'(h_low_line0),    32'd96);
        check_val("h_sync_low_line1",    32'(h_low_line1),    32'd96);
        check_val("disp_ena_two_lines",  32'(de_two_lines),   32'd1280);
        check_val("pol_h_high_line0",    32'(pol_high_line0), 32'd96);
        check_val("n_blank_vs_disp_ena", 32'(nb_mismatch),    32'd0);
        check_val("n_sync_nonzero",      32'(nsync_ones),     32'd0);
        check_val("pol_inverse_mism",    32'(pol_mismatch),   32'd0);
        check_val("main_frame_starts",   32'(main_fs_count),  32'd1);
        check_val("tiny_v_sync_high",    32'(tiny_vs_high),   32'd30);
        check_val("tiny_h_sync_high",    32'(tiny_hs_high),   32'd24);
        check_val("tiny_disp_ena_frame", 32'(tiny_de_count),  32'd32);
        check_val("tiny_frame_starts",   32'(tiny_fs_count),  32'd2);
        check_val("tiny_frame_period",   32'(tiny_fs_second - tiny_fs_first), 32'd120);

        // Mid-frame asynchronous reset, between clock edges.
        #5 reset_n = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 1; k <= 641; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_start("run2", k);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
